// File: rtl/mem_arbiter_if.sv
// Signal bundle joining the CPU inst/data request ports, the arbiter and the bus bridge.
// The arbiter takes the slave view; the core plus bridge side takes the master view.
interface mem_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_req;
   logic        mem_wr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wr, data_wstrb, data_addr, data_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access:
// data has priority, capped by a starvation counter so fetch always progresses.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 3,
   parameter logic [31:0] ADDR_MASK  = 32'h1fff_ffff
) (
   input  logic         clk,
   input  logic         resetn,
   mem_arbiter_if.slave bus,
   output logic         busy
);
   localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [CW-1:0]  starve_cnt_reg, starve_cnt_next;
   logic           owner_data_reg, owner_data_next;
   logic           wr_reg, wr_next;
   logic [3:0]     wstrb_reg, wstrb_next;
   logic [31:0]    addr_reg, addr_next;
   logic [31:0]    wdata_reg, wdata_next;

   logic           grant_data;
   logic           inst_addr_ok;
   logic           data_addr_ok;
   logic           mem_req;
   logic           done;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg      <= IDLE;
         starve_cnt_reg <= '0;
         owner_data_reg <= 1'b1;
         wr_reg         <= 1'b0;
         wstrb_reg      <= 4'b0000;
         addr_reg       <= 32'h0;
         wdata_reg      <= 32'h0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
         owner_data_reg <= owner_data_next;
         wr_reg         <= wr_next;
         wstrb_reg      <= wstrb_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      starve_cnt_next = starve_cnt_reg;
      owner_data_next = owner_data_reg;
      wr_next         = wr_reg;
      wstrb_next      = wstrb_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      inst_addr_ok    = 1'b0;
      data_addr_ok    = 1'b0;
      mem_req         = 1'b0;
      done            = 1'b0;
      // Data wins unless fetch is waiting and has already been passed over STARVE_MAX times.
      grant_data = bus.data_req && (!bus.inst_req || (starve_cnt_reg < STARVE_LIM));

      case (state_reg)
         IDLE: begin
            if (bus.data_req || bus.inst_req) begin
               state_next = REQ;
               addr_next  = grant_data ? (bus.data_addr & ADDR_MASK) : (bus.inst_addr & ADDR_MASK);
               if (grant_data) begin
                  data_addr_ok    = 1'b1;
                  owner_data_next = 1'b1;
                  wr_next         = bus.data_wr;
                  wstrb_next      = bus.data_wr ? bus.data_wstrb : 4'b0000;
                  wdata_next      = bus.data_wdata;
                  if (bus.inst_req && (starve_cnt_reg < STARVE_LIM))
                     starve_cnt_next = starve_cnt_reg + CW'(1);
               end else begin
                  inst_addr_ok    = 1'b1;
                  owner_data_next = 1'b0;
                  wr_next         = 1'b0;
                  wstrb_next      = 4'b0000;
                  wdata_next      = 32'h0;
                  starve_cnt_next = '0;
               end
            end
         end
         REQ: begin
            mem_req = 1'b1;
            if (bus.mem_addr_ok) begin
               if (bus.mem_data_ok) begin
                  done       = 1'b1;
                  state_next = IDLE;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (bus.mem_data_ok) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.inst_addr_ok = inst_addr_ok;
   assign bus.data_addr_ok = data_addr_ok;
   assign bus.inst_data_ok = done && !owner_data_reg;
   assign bus.data_data_ok = done && owner_data_reg;
   assign bus.inst_rdata   = (done && !owner_data_reg) ? bus.mem_rdata : 32'h0;
   assign bus.data_rdata   = (done && owner_data_reg) ? bus.mem_rdata : 32'h0;
   assign bus.mem_req      = mem_req;
   assign bus.mem_wr       = wr_reg;
   assign bus.mem_wstrb    = wstrb_reg;
   assign bus.mem_addr     = addr_reg;
   assign bus.mem_wdata    = wdata_reg;
   assign busy             = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: requesters and a bridge model drive the DUT,
// a monitor pops expected grants, memory fields and responses as the DUT presents them.
module tb_mem_arbiter;
   logic clk;
   logic resetn;
   logic busy;

   mem_arbiter_if bus();

   mem_arbiter #(
      .STARVE_MAX (2),
      .ADDR_MASK  (32'h1fff_ffff)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus),
      .busy   (busy)
   );

   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct packed {
      logic        is_data;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      int          a_lat;
      int          d_lat;
      logic [31:0] rdata;
   } cfg_t;

   bit       exp_grant[$];
   mem_exp_t exp_mem[$];
   resp_t    exp_resp[$];
   cfg_t     cfg_q[$];
   int       grant_cyc[$];

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic        br_aok, br_dok, stray_dok;
   logic [31:0] br_rdata, stray_rdata;

   assign bus.mem_addr_ok = br_aok;
   assign bus.mem_data_ok = br_dok | stray_dok;
   assign bus.mem_rdata   = br_rdata | stray_rdata;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue one expected transaction in grant order; want_resp=0 for one that is abandoned.
   task automatic exp_txn(input bit is_data, input logic wr, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int a_lat, input int d_lat, input logic [31:0] rdata,
                          input bit want_resp);
      mem_exp_t m;
      resp_t    r;
      cfg_t     c;
      m = '{wr: wr, wstrb: wstrb, addr: addr, wdata: wdata};
      r = '{is_data: is_data, rdata: rdata};
      c = '{a_lat: a_lat, d_lat: d_lat, rdata: rdata};
      exp_grant.push_back(is_data);
      exp_mem.push_back(m);
      cfg_q.push_back(c);
      if (want_resp) exp_resp.push_back(r);
   endtask

   task automatic do_inst(input logic [31:0] addr);
      int  n   = 0;
      bit  got = 0;
      bus.inst_req  = 1'b1;
      bus.inst_addr = addr;
      while (!got && n < 200) begin
         @(negedge clk); #3;
         got = bus.inst_addr_ok;
         n   = n + 1;
      end
      chk("inst_accept_timeout", got, 1);
      @(posedge clk); #1;
      bus.inst_req  = 1'b0;
      bus.inst_addr = 32'h0;
   endtask

   task automatic do_data(input logic wr, input logic [3:0] wstrb,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int  n   = 0;
      bit  got = 0;
      bus.data_req   = 1'b1;
      bus.data_wr    = wr;
      bus.data_wstrb = wstrb;
      bus.data_addr  = addr;
      bus.data_wdata = wdata;
      while (!got && n < 200) begin
         @(negedge clk); #3;
         got = bus.data_addr_ok;
         n   = n + 1;
      end
      chk("data_accept_timeout", got, 1);
      @(posedge clk); #1;
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_wstrb = 4'b0000;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 32'h0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_resp.size() != 0 || busy) && n < 200) begin
         @(negedge clk); #3;
         n = n + 1;
      end
      chk("drain_timeout", {exp_resp.size() == 0, !busy}, 2'b11);
      @(posedge clk); #1;
   endtask

   // Bridge model: samples mem_req mid-cycle, answers after the queued latencies.
   initial begin : bridge
      cfg_t c;
      br_aok   = 1'b0;
      br_dok   = 1'b0;
      br_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.mem_req && resetn) begin
            if (cfg_q.size() != 0) c = cfg_q.pop_front();
            else c = '{a_lat: 0, d_lat: 1, rdata: 32'h0};
            repeat (c.a_lat) @(negedge clk);
            #1;
            br_aok = 1'b1;
            if (c.d_lat == 0) begin
               br_dok   = 1'b1;
               br_rdata = c.rdata;
            end
            @(negedge clk); #1;
            br_aok   = 1'b0;
            br_dok   = 1'b0;
            br_rdata = 32'h0;
            if (c.d_lat > 0) begin
               repeat (c.d_lat - 1) @(negedge clk);
               #1;
               br_dok   = 1'b1;
               br_rdata = c.rdata;
               @(negedge clk); #1;
               br_dok   = 1'b0;
               br_rdata = 32'h0;
            end
         end
      end
   end

   initial begin : monitor
      bit       g;
      bit       mem_prev = 1'b0;
      bit       have_cur = 1'b0;
      mem_exp_t cur;
      resp_t    r;
      forever begin
         @(negedge clk); #3;
         if (bus.inst_addr_ok || bus.data_addr_ok) begin
            chk("grant_exclusive", bus.inst_addr_ok & bus.data_addr_ok, 0);
            chk("grant_expected", exp_grant.size() != 0, 1);
            grant_cyc.push_back(cyc);
            if (exp_grant.size() != 0) begin
               g = exp_grant.pop_front();
               chk("grant_who", bus.data_addr_ok, g);
               $display("grant %s at cycle %0d", bus.data_addr_ok ? "data" : "inst", cyc);
            end
         end
         if (bus.mem_req) begin
            if (!mem_prev) begin
               chk("mem_expected", exp_mem.size() != 0, 1);
               have_cur = (exp_mem.size() != 0);
               if (have_cur) cur = exp_mem.pop_front();
            end
            if (have_cur)
               chk("mem_fields", {bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata}, cur);
         end
         mem_prev = bus.mem_req;
         if (bus.inst_data_ok || bus.data_data_ok) begin
            chk("dok_exclusive", bus.inst_data_ok & bus.data_data_ok, 0);
            chk("resp_expected", exp_resp.size() != 0, 1);
            if (exp_resp.size() != 0) begin
               r = exp_resp.pop_front();
               chk("resp_who", bus.data_data_ok, r.is_data);
               chk("resp_rdata", bus.data_data_ok ? bus.data_rdata : bus.inst_rdata, r.rdata);
               chk("resp_other_rdata", bus.data_data_ok ? bus.inst_rdata : bus.data_rdata, 0);
               $display("resp %s rdata=0x%08h at cycle %0d",
                        bus.data_data_ok ? "data" : "inst", r.rdata, cyc);
            end
         end else if (bus.mem_data_ok) begin
            chk("rdata_gated", {bus.inst_rdata, bus.data_rdata}, 0);
         end
      end
   end

   initial begin : main
      int n;
      bit seen;
      bus.inst_req   = 1'b0;
      bus.inst_addr  = 32'h0;
      bus.data_req   = 1'b0;
      bus.data_wr    = 1'b0;
      bus.data_wstrb = 4'b0000;
      bus.data_addr  = 32'h0;
      bus.data_wdata = 32'h0;
      stray_dok      = 1'b0;
      stray_rdata    = 32'h0;
      resetn         = 1'b0;

      repeat (2) @(negedge clk);
      #3;
      chk("reset_outputs", {bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
                            bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok,
                            bus.data_data_ok, busy}, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;

      // Lone fetch from kseg1 boot vector; addr_ok one cycle into REQ, data two later.
      exp_txn(0, 0, 4'h0, 32'h1FC0_0000, 32'h0, 1, 2, 32'h2408_0001, 1);
      do_inst(32'hBFC0_0000);
      wait_idle();

      // Simultaneous store and fetch: data first, fetch after the store completes.
      exp_txn(1, 1, 4'hF, 32'h0000_0040, 32'hDEAD_BEEF, 0, 1, 32'h0, 1);
      exp_txn(0, 0, 4'h0, 32'h1FC0_0004, 32'h0, 0, 1, 32'h8C02_0000, 1);
      fork
         do_data(1'b1, 4'hF, 32'hA000_0040, 32'hDEAD_BEEF);
         do_inst(32'hBFC0_0004);
      join
      wait_idle();

      // Both held continuously with STARVE_MAX=2: D,D,I,D,D,I.
      exp_txn(1, 1, 4'h3, 32'h0000_1000, 32'h1000_0000, 0, 0, 32'h0000_00D0, 1);
      exp_txn(1, 1, 4'h3, 32'h0000_1004, 32'h1000_0001, 1, 1, 32'h0000_00D1, 1);
      exp_txn(0, 0, 4'h0, 32'h1FC0_0100, 32'h0,         2, 1, 32'h3C00_0000, 1);
      exp_txn(1, 1, 4'h3, 32'h0000_1008, 32'h1000_0002, 0, 2, 32'h0000_00D2, 1);
      exp_txn(1, 1, 4'h3, 32'h0000_100C, 32'h1000_0003, 0, 1, 32'h0000_00D3, 1);
      exp_txn(0, 0, 4'h0, 32'h1FC0_0104, 32'h0,         1, 0, 32'h3C00_0001, 1);
      fork
         for (int k = 0; k < 4; k++)
            do_data(1'b1, 4'h3, 32'h8000_1000 + 32'(4 * k), 32'h1000_0000 + 32'(k));
         for (int k = 0; k < 2; k++)
            do_inst(32'hBFC0_0100 + 32'(4 * k));
      join
      wait_idle();

      // Same-cycle addr_ok/data_ok: the next grant lands two cycles after the first.
      grant_cyc.delete();
      exp_txn(1, 1, 4'h8, 32'h0000_2000, 32'h55AA_55AA, 0, 0, 32'h0, 1);
      exp_txn(0, 0, 4'h0, 32'h1FC0_0200, 32'h0,         0, 1, 32'h0BAD_0001, 1);
      fork
         do_data(1'b1, 4'h8, 32'h0000_2000, 32'h55AA_55AA);
         do_inst(32'hBFC0_0200);
      join
      wait_idle();
      chk("b2b_grant_gap", (grant_cyc.size() == 2) ? (grant_cyc[1] - grant_cyc[0]) : -1, 2);

      // Reset while waiting for data: outputs clear at once, late data_ok is dropped.
      exp_txn(0, 0, 4'h0, 32'h1FC0_0020, 32'h0, 0, 4, 32'h1234_5678, 0);
      do_inst(32'hBFC0_0020);
      @(posedge clk); #1;
      chk("in_wait_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("reset_in_wait", {bus.mem_req, bus.mem_wr, bus.mem_wstrb, bus.mem_addr, bus.mem_wdata,
                            bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata,
                            bus.data_rdata, busy}, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 10) begin
         @(negedge clk); #3;
         seen = bus.mem_data_ok;
         n    = n + 1;
      end
      chk("late_dok_seen", seen, 1);
      chk("late_dok_dropped", {bus.inst_data_ok, bus.data_data_ok}, 0);
      @(posedge clk); #1;
      exp_txn(0, 0, 4'h0, 32'h1FC0_0030, 32'h0, 1, 1, 32'hA5A5_A5A5, 1);
      do_inst(32'hBFC0_0030);
      wait_idle();

      // Load with strobes set: strobes forced to zero on the memory side.
      exp_txn(1, 0, 4'h0, 32'h0000_0008, 32'h1122_3344, 1, 1, 32'h0000_00AB, 1);
      do_data(1'b0, 4'b0100, 32'hC000_0008, 32'h1122_3344);
      wait_idle();

      // Stray mem_data_ok while idle.
      stray_dok   = 1'b1;
      stray_rdata = 32'hCAFE_F00D;
      @(negedge clk); #3;
      chk("stray_dok", {bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata,
                        bus.data_rdata, busy}, 0);
      @(posedge clk); #1;
      stray_dok   = 1'b0;
      stray_rdata = 32'h0;
      @(posedge clk); #1;

      // Store with no strobes is forwarded unchanged.
      exp_txn(1, 1, 4'h0, 32'h0000_3000, 32'h7777_7777, 0, 1, 32'h0, 1);
      do_data(1'b1, 4'b0000, 32'h0000_3000, 32'h7777_7777);
      wait_idle();

      repeat (3) @(posedge clk);
      chk("leftover_expectations", {32'(exp_grant.size()), 32'(exp_mem.size()),
                                    32'(exp_resp.size()), 32'(cfg_q.size())}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
